// File: rtl/bcd_display_if.sv
`default_nettype none
// ============================================================================
// Module   : bcd_display_if
// Purpose  : Request/result bundle between a binary source and bcd_display.
//            The HEX member exists only when SEG7_DECODE_EN is defined.
// Revision : 1.0
// ============================================================================
interface bcd_display_if #(
   parameter int WIDTH  = 10,
   parameter int DIGITS = 4
);
   logic [WIDTH-1:0]    bin;
   logic                load;
   logic                busy;
   logic                valid;
   logic [4*DIGITS-1:0] bcd;
`ifdef SEG7_DECODE_EN
   logic [7*DIGITS-1:0] HEX;

   modport master (output bin, load, input busy, valid, bcd, HEX);
   modport slave  (input bin, load, output busy, valid, bcd, HEX);
`else
   modport master (output bin, load, input busy, valid, bcd);
   modport slave  (input bin, load, output busy, valid, bcd);
`endif
endinterface
`default_nettype wire

// File: rtl/bcd_display.sv
`default_nettype none
// ============================================================================
// Module   : bcd_display
// Purpose  : Iterative double-dabble binary-to-BCD converter, one bit per clock,
//            with optional active-low 7-segment decode (macro SEG7_DECODE_EN).
// Revision : 1.0
// ============================================================================
module bcd_display #(
   parameter int WIDTH  = 10,
   parameter int DIGITS = 4
) (
   input  wire           CLOCK_50,
   input  wire           Resetn,
   bcd_display_if.slave  disp
);
   localparam int BCD_W = 4 * DIGITS;
   localparam int CNT_W = $clog2(WIDTH + 1);

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      CONV = 1'b1
   } state_t;

   state_t             state_q, state_d;
   logic [WIDTH-1:0]   shift_q, shift_d;
   logic [BCD_W-1:0]   scratch_q, scratch_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [BCD_W-1:0]   bcd_q, bcd_d;
   logic               valid_q, valid_d;
   logic [BCD_W-1:0]   adj;

   always_ff @(posedge CLOCK_50 or negedge Resetn) begin
      if (!Resetn) begin
         state_q   <= IDLE;
         shift_q   <= '0;
         scratch_q <= '0;
         cnt_q     <= '0;
         bcd_q     <= '0;
         valid_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         shift_q   <= shift_d;
         scratch_q <= scratch_d;
         cnt_q     <= cnt_d;
         bcd_q     <= bcd_d;
         valid_q   <= valid_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      shift_d   = shift_q;
      scratch_d = scratch_q;
      cnt_d     = cnt_q;
      bcd_d     = bcd_q;
      valid_d   = 1'b0;
      adj       = scratch_q;

      // Nibbles >= 5 would exceed 9 after doubling, so pre-correct them by 3.
      for (int i = 0; i < DIGITS; i++) begin
         if (scratch_q[4*i +: 4] >= 4'd5) begin
            adj[4*i +: 4] = scratch_q[4*i +: 4] + 4'd3;
         end
      end

      case (state_q)
         IDLE: begin
            if (disp.load) begin
               shift_d   = disp.bin;
               scratch_d = '0;
               cnt_d     = CNT_W'(WIDTH);
               state_d   = CONV;
            end
         end
         CONV: begin
            {scratch_d, shift_d} = {adj[BCD_W-2:0], shift_q, 1'b0};
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
               bcd_d   = scratch_d;
               valid_d = 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign disp.busy  = (state_q == CONV);
   assign disp.valid = valid_q;
   assign disp.bcd   = bcd_q;

`ifdef SEG7_DECODE_EN
   function automatic logic [6:0] seg7(input logic [3:0] code);
      logic [6:0] seg;
      case (code)
         4'd0:    seg = 7'b1000000;
         4'd1:    seg = 7'b1111001;
         4'd2:    seg = 7'b0100100;
         4'd3:    seg = 7'b0110000;
         4'd4:    seg = 7'b0011001;
         4'd5:    seg = 7'b0010010;
         4'd6:    seg = 7'b0000010;
         4'd7:    seg = 7'b1111000;
         4'd8:    seg = 7'b0000000;
         4'd9:    seg = 7'b0010000;
         default: seg = 7'b1111111;
      endcase
      return seg;
   endfunction

   for (genvar gi = 0; gi < DIGITS; gi++) begin : g_seg
      assign disp.HEX[7*gi +: 7] = seg7(bcd_q[4*gi +: 4]);
   end
`endif

endmodule
`default_nettype wire
